pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-bit-PC pipelined CPU.
- Watches the ID stage (fetch_decode outputs) and the EX stage.
- Resolves load-use hazards, jump redirects and halt draining.
- Drives stall, hold, flush and bubble controls into the PC register, IF/ID and ID/EX pipeline registers.
- Keeps a saturating stall-cycle performance counter.

Parameters:
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7).
DRAIN_CYCLES, 3, cycles to drain EX/MEM/WB after halt before asserting halted (1..7).
CNT_W, 16, width of stall_cycles counter.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  synchronous active-low reset.
id_rr1  in  5  ID-stage source reg 1.
id_rr2  in  5  ID-stage source reg 2.
id_uses_rr1  in  1  ID instruction reads rr1.
id_uses_rr2  in  1  ID instruction reads rr2.
id_halt  in  1  ID instruction is halt.
ex_write_reg  in  5  EX-stage destination reg.
ex_reg_wrenable  in  1  EX instruction writes regfile.
ex_mem_to_reg  in  1  EX instruction is a load.
ex_should_jump  in  1  jump/branch taken, resolved in EX.
pc_stall  out  1  hold PC this cycle.
ifid_hold  out  1  hold IF/ID register.
ifid_flush  out  1  load NOP into IF/ID.
idex_bubble  out  1  load NOP into ID/EX.
halted  out  1  core halted.
state  out  3  FSM state encoding, for debug.
stall_cycles  out  CNT_W  saturating count of hazard stall cycles.

Behaviour:
- FSM states: RUN=0, STALL=1, DRAIN=2, HALTED=3.
- Reset: rst_n sampled low at a clock edge -> state=RUN, stall counter=0, stall_cycles=0. Applies from any state, including mid-STALL or mid-DRAIN.
- While rst_n=0, outputs are forced combinationally: pc_stall=1, all other controls=0, halted=0.
- All controls are combinational from state, internal counter and inputs; state and counters update on posedge clk.
- load_use = ex_reg_wrenable & ex_mem_to_reg & (ex_write_reg!=0) & ((id_uses_rr1 & id_rr1==ex_write_reg) | (id_uses_rr2 & id_rr2==ex_write_reg)).
- Register x0 never causes a hazard.
- Priority in RUN: ex_should_jump > load_use > id_halt.
- RUN + ex_should_jump:
  - ifid_flush=1, idex_bubble=1, pc_stall=0, so the PC loads the jump target.
  - Stay RUN.
  - A simultaneous load_use or id_halt is a wrong-path instruction and is ignored.
- RUN + load_use (no jump):
  - pc_stall=1, ifid_hold=1, idex_bubble=1 in the same cycle (0-cycle detection latency).
  - If LOAD_STALL_CYCLES>1: go STALL, cnt=LOAD_STALL_CYCLES-2. Otherwise stay RUN.
- RUN + id_halt (no jump, no load_use):
  - pc_stall=1, ifid_flush=1, idex_bubble=1 (halt retires as a bubble).
  - Go DRAIN, cnt=DRAIN_CYCLES-1.
- A halt that also has a load_use is stalled first and re-evaluated once the hazard clears.
- STALL:
  - pc_stall=1, ifid_hold=1, idex_bubble=1.
  - cnt==0 -> RUN, else cnt-1.
  - ex_should_jump in STALL cannot occur (EX holds a bubble) and is ignored.
- DRAIN:
  - pc_stall=1, ifid_flush=1, idex_bubble=1.
  - All inputs are ignored.
  - cnt==0 -> HALTED, else cnt-1.
- HALTED:
  - pc_stall=1, ifid_flush=1, idex_bubble=1, halted=1.
  - Absorbing state; leaves only via reset.
- stall_cycles:
  - +1 on every edge where the cycle had pc_stall=1 due to load_use or STALL.
  - Not incremented in DRAIN, HALTED or reset.
  - Saturates at all-ones; no wrap.
- ifid_hold and ifid_flush are never both 1. When both apply, flush wins.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum (RUN/STALL/DRAIN/HALTED, 3-bit);
  - REG_W=5, PC_W=5, NOP encoding constant;
  - ZERO_REG=5'd0.
- One natural sub-module: sat_counter (parameter W; inc, clear inputs; saturating), used for stall_cycles.
- The hazard comparator stays inline.

Test Plan:
1. Reset then idle, no hazards, 10 cycles -> state=0, all controls 0, stall_cycles=0.
2. Load-use: ex_mem_to_reg=1, ex_reg_wrenable=1, ex_write_reg=5, id_rr2=5, id_uses_rr2=1 -> pc_stall=ifid_hold=idex_bubble=1 for exactly 1 cycle, stall_cycles=1. Repeat with LOAD_STALL_CYCLES=3 -> 3 cycles asserted, stall_cycles=3. Repeat with ex_write_reg=0 -> no stall.
3. Jump priority: ex_should_jump=1 together with a load_use and id_halt -> ifid_flush=idex_bubble=1, pc_stall=0, state stays RUN, stall_cycles unchanged.
4. Halt: id_halt=1 -> DRAIN for 3 cycles, halted rises on the 4th cycle after the halt cycle and stays 1 for 20 further cycles regardless of inputs.
5. Reset mid-DRAIN and mid-STALL (LOAD_STALL_CYCLES=3, rst_n low 1 cycle) -> next cycle state=RUN, halted=0, stall_cycles=0; pc_stall=1 during the reset cycle.
6. Saturation with CNT_W=4: 20 back-to-back load-use stalls -> stall_cycles holds at 15.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 5-bit-PC pipelined CPU.
package cpu_pkg;

    localparam int REG_W = 5;
    localparam int PC_W  = 5;

    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;
    localparam logic [15:0]      NOP      = 16'h0000;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        STALL  = 3'd1,
        DRAIN  = 3'd2,
        HALTED = 3'd3
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clear) begin
            q <= '0;
        end else if (inc && q != '1) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, jump flushes, halt drain.
module pipeline_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int DRAIN_CYCLES      = 3,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rr1,
    input  logic [REG_W-1:0] id_rr2,
    input  logic             id_uses_rr1,
    input  logic             id_uses_rr2,
    input  logic             id_halt,
    input  logic [REG_W-1:0] ex_write_reg,
    input  logic             ex_reg_wrenable,
    input  logic             ex_mem_to_reg,
    input  logic             ex_should_jump,
    output logic             pc_stall,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] stall_cycles
);

    state_e     st;
    logic [2:0] cnt;
    logic       hit1;
    logic       hit2;
    logic       load_use;
    logic       inc;

    assign hit1 = id_uses_rr1 && id_rr1 == ex_write_reg;
    assign hit2 = id_uses_rr2 && id_rr2 == ex_write_reg;
    assign load_use = ex_reg_wrenable && ex_mem_to_reg &&
                      ex_write_reg != ZERO_REG && (hit1 || hit2);

    assign state = st;

    always_comb begin
        pc_stall    = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        halted      = 1'b0;
        inc         = 1'b0;
        if (!rst_n) begin
            pc_stall = 1'b1;
        end else begin
            unique case (st)
                RUN: begin
                    if (ex_should_jump) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_stall    = 1'b1;
                        ifid_hold   = 1'b1;
                        idex_bubble = 1'b1;
                        inc         = 1'b1;
                    end else if (id_halt) begin
                        pc_stall    = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end
                end
                STALL: begin
                    pc_stall    = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                    inc         = 1'b1;
                end
                DRAIN: begin
                    pc_stall    = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end
                HALTED: begin
                    pc_stall    = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    halted      = 1'b1;
                end
                default: begin
                    pc_stall = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st  <= RUN;
            cnt <= '0;
        end else begin
            unique case (st)
                RUN: begin
                    // Jump wins: anything else in ID is wrong-path.
                    if (ex_should_jump) begin
                        st <= RUN;
                    end else if (load_use) begin
                        if (LOAD_STALL_CYCLES > 1) begin
                            st  <= STALL;
                            cnt <= 3'(LOAD_STALL_CYCLES - 2);
                        end
                    end else if (id_halt) begin
                        st  <= DRAIN;
                        cnt <= 3'(DRAIN_CYCLES - 1);
                    end
                end
                STALL: begin
                    if (cnt == 3'd0) st <= RUN;
                    else cnt <= cnt - 3'd1;
                end
                DRAIN: begin
                    if (cnt == 3'd0) st <= HALTED;
                    else cnt <= cnt - 3'd1;
                end
                HALTED: st <= HALTED;
                default: st <= RUN;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (!rst_n),
        .inc   (inc),
        .q     (stall_cycles)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with a cycle-level model.
module tb_pipeline_hazard_ctrl;

    localparam int LSC  = 3;
    localparam int DRN  = 3;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic          ps;
        logic          ho;
        logic          fl;
        logic          bu;
        logic          ha;
        logic [2:0]    st;
        logic [CW-1:0] sc;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    id_rr1 = '0;
    logic [4:0]    id_rr2 = '0;
    logic          id_uses_rr1 = 1'b0;
    logic          id_uses_rr2 = 1'b0;
    logic          id_halt = 1'b0;
    logic [4:0]    ex_write_reg = '0;
    logic          ex_reg_wrenable = 1'b0;
    logic          ex_mem_to_reg = 1'b0;
    logic          ex_should_jump = 1'b0;
    logic          pc_stall;
    logic          ifid_hold;
    logic          ifid_flush;
    logic          idex_bubble;
    logic          halted;
    logic [2:0]    state;
    logic [CW-1:0] stall_cycles;

    int total = 0;
    int bad = 0;

    obs_t  exp_q[$];
    string tag_q[$];

    // model state: plain counters of remaining cycles
    int  m_stall_left = 0;
    int  m_drain_left = 0;
    bit  m_halted = 0;
    int  m_count = 0;

    pipeline_hazard_ctrl #(
        .LOAD_STALL_CYCLES (LSC),
        .DRAIN_CYCLES      (DRN),
        .CNT_W             (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rr1          (id_rr1),
        .id_rr2          (id_rr2),
        .id_uses_rr1     (id_uses_rr1),
        .id_uses_rr2     (id_uses_rr2),
        .id_halt         (id_halt),
        .ex_write_reg    (ex_write_reg),
        .ex_reg_wrenable (ex_reg_wrenable),
        .ex_mem_to_reg   (ex_mem_to_reg),
        .ex_should_jump  (ex_should_jump),
        .pc_stall        (pc_stall),
        .ifid_hold       (ifid_hold),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .halted          (halted),
        .state           (state),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic bit hazard();
        logic [4:0] src [2];
        bit         use_src [2];
        bit         h;
        src[0] = id_rr1;
        src[1] = id_rr2;
        use_src[0] = id_uses_rr1;
        use_src[1] = id_uses_rr2;
        h = 0;
        if (ex_mem_to_reg && ex_reg_wrenable && ex_write_reg != 0)
            for (int k = 0; k < 2; k++)
                if (use_src[k] && src[k] == ex_write_reg) h = 1;
        return h;
    endfunction

    task automatic model_step(input string tag);
        obs_t e;
        int   cur;
        e = '0;
        cur = m_halted ? 3 : (m_drain_left > 0) ? 2 :
              (m_stall_left > 0) ? 1 : 0;
        e.st = 3'(cur);
        e.sc = CW'(m_count);
        if (!rst_n) begin
            e.ps = 1;
            m_stall_left = 0;
            m_drain_left = 0;
            m_halted = 0;
            m_count = 0;
        end else if (m_halted) begin
            e.ps = 1; e.fl = 1; e.bu = 1; e.ha = 1;
        end else if (m_drain_left > 0) begin
            e.ps = 1; e.fl = 1; e.bu = 1;
            m_drain_left--;
            if (m_drain_left == 0) m_halted = 1;
        end else if (m_stall_left > 0) begin
            e.ps = 1; e.ho = 1; e.bu = 1;
            m_stall_left--;
            if (m_count < CMAX) m_count++;
        end else if (ex_should_jump) begin
            e.fl = 1; e.bu = 1;
        end else if (hazard()) begin
            e.ps = 1; e.ho = 1; e.bu = 1;
            m_stall_left = LSC - 1;
            if (m_count < CMAX) m_count++;
        end else if (id_halt) begin
            e.ps = 1; e.fl = 1; e.bu = 1;
            m_drain_left = DRN;
        end
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic drive(input string tag, input bit rst,
                         input int r1, input int r2,
                         input bit u1, input bit u2, input bit hlt,
                         input int wr, input bit we, input bit ld,
                         input bit jmp);
        @(posedge clk);
        #1;
        rst_n = rst;
        id_rr1 = 5'(r1);
        id_rr2 = 5'(r2);
        id_uses_rr1 = u1;
        id_uses_rr2 = u2;
        id_halt = hlt;
        ex_write_reg = 5'(wr);
        ex_reg_wrenable = we;
        ex_mem_to_reg = ld;
        ex_should_jump = jmp;
        model_step(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++)
            drive(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // monitor: compares whatever the DUT shows against the queue head
    initial begin
        obs_t  a;
        obs_t  e;
        string t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = {pc_stall, ifid_hold, ifid_flush, idex_bubble,
                     halted, state, stall_cycles};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL %s: got ps%b ho%b fl%b bu%b ha%b st%0d sc%0d want ps%b ho%b fl%b bu%b ha%b st%0d sc%0d",
                             t, a.ps, a.ho, a.fl, a.bu, a.ha, a.st, a.sc,
                             e.ps, e.ho, e.fl, e.bu, e.ha, e.st, e.sc);
                end
                total++;
                if (ifid_hold && ifid_flush) begin
                    bad++;
                    $display("FAIL %s hold_flush_excl: got both=1 want 0", t);
                end
            end
        end
    end

    initial begin
        int rnd_rst;
        drive("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("idle", 10);
        drive("load_use_rr2", 1, 0, 5, 0, 1, 0, 5, 1, 1, 0);
        idle("load_use_tail", 5);
        drive("load_use_x0", 1, 0, 0, 1, 1, 0, 0, 1, 1, 0);
        drive("load_use_rr1", 1, 7, 3, 1, 0, 0, 7, 1, 1, 0);
        idle("rr1_tail", 4);
        drive("no_wren", 1, 9, 9, 1, 1, 0, 9, 0, 1, 0);
        drive("jump_prio", 1, 4, 4, 1, 1, 1, 4, 1, 1, 1);
        idle("post_jump", 2);
        drive("halt_load", 1, 6, 0, 1, 0, 1, 6, 1, 1, 0);
        for (int i = 0; i < 6; i++)
            drive("halt_drain", 1, 0, 0, 0, 0, 1, 0, 0, 0,
                  bit'($urandom_range(0, 1)));
        for (int i = 0; i < 20; i++)
            drive("halted_hold", 1, $urandom_range(0, 3),
                  $urandom_range(0, 3), 1, 1, 1, $urandom_range(0, 3),
                  1, 1, bit'($urandom_range(0, 1)));
        drive("reset_halted", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("after_reset", 2);
        drive("halt2", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        drive("drain_mid", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive("reset_drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("after_rst_drain", 3);
        drive("stall_start", 1, 2, 0, 1, 0, 0, 2, 1, 1, 0);
        drive("stall_mid", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive("reset_stall", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("after_rst_stall", 3);
        for (int i = 0; i < 60; i++)
            drive("saturate", 1, 3, 3, 1, 1, 0, 3, 1, 1, 0);
        idle("sat_hold", 3);
        for (int i = 0; i < 2500; i++) begin
            rnd_rst = m_halted ? 15 : 3;
            drive("random", ($urandom_range(0, 99) >= rnd_rst),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) < 2), $urandom_range(0, 3),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) < 10));
        end
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_queue: got %0d left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
